alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have port instr_valid, input, 1, instruction offered.
REQ-004 SHALL have port instr_ready, output, 1, sequencer accepts instruction this cycle.
REQ-005 SHALL have port instr_op, input, 3, opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 LDI, 110 MUL, 111 reserved.
REQ-006 SHALL have ports instr_rd, instr_rs1, instr_rs2, input, 2 each, destination and source register indices.
REQ-007 SHALL have port instr_imm, input, 16, LDI immediate.
REQ-008 SHALL have port done, output, 1, one-cycle pulse on writeback.
REQ-009 SHALL have port err, output, 1, one-cycle pulse on rejected opcode.
REQ-010 SHALL have ports dbg_sel (input, 2) and dbg_data (output, 16), combinational read of register dbg_sel.

Function
REQ-011 SHALL contain register file R[3:0], 16 bits each, written only by this block.
REQ-012 SHALL implement FSM states IDLE, EXEC, MUL, WB; instr_ready = 1 only in IDLE.
REQ-013 SHALL accept on instr_valid & instr_ready; latch op, rd, imm, R[rs1], R[rs2] at that edge; IDLE->EXEC.
REQ-014 SHALL, in EXEC, compute result into a 16-bit result register; EXEC->WB (non-MUL ops) or EXEC->MUL (MUL).
REQ-015 SHALL compute ADD/SUB modulo 2^16 (0xFFFF+0x0001=0x0000, 0x0000-0x0001=0xFFFF); AND/OR bitwise; SLT unsigned, result 0x0001 or 0x0000; LDI result = imm.
REQ-016 SHALL, in WB, write result to R[rd] at the end of the cycle, assert done for that cycle, then WB->IDLE.
REQ-017 SHALL give non-MUL latency: accept edge at cycle N, done high in cycle N+2, new R[rd] visible on dbg_data in cycle N+3; max throughput one instruction per 3 cycles.
REQ-018 SHALL use operands captured at accept; rd equal to rs1/rs2 reads the old value.
REQ-019 SHALL, on reserved opcode (or MUL when compiled out), go EXEC->IDLE without writeback, pulse err in the EXEC cycle, no done.
REQ-020 SHALL ignore instr_* inputs outside IDLE; an instruction held valid while not ready is accepted on return to IDLE.
REQ-021 SHALL keep done and err mutually exclusive, never asserted in IDLE.

Reset
REQ-022 SHALL, on rst high, immediately force state IDLE, R[0..3]=0x0000, result=0, mul counter=0, done=0, err=0.
REQ-023 SHALL drive instr_ready=1 once rst deasserts; instr_ready=0 while rst high.
REQ-024 SHALL abort any in-flight instruction on reset mid-operation with no writeback.

Configuration
REQ-025 SHALL, with macro ALU_SEQ_MUL_EN defined, implement MUL: shift-add unsigned multiply, 16 cycles in MUL state (4-bit counter 0..15), low 16 bits of product written in WB; done 18 cycles after accept edge.
REQ-026 SHALL, without ALU_SEQ_MUL_EN, omit MUL state and multiplier logic; op 110 handled as reserved per REQ-019.

Verification
REQ-027 SHALL cover: reset, LDI R0=0xFFFF, LDI R1=0x0001, ADD rd=2 rs1=0 rs2=1 -> done at N+2, dbg_sel=2 reads 0x0000.
REQ-028 SHALL cover: R0=0x0000, R1=0x0001, SUB rd=3 -> R3=0xFFFF; SLT rd=2 rs1=0 rs2=1 -> R2=0x0001; SLT rs1=1 rs2=0 -> 0x0000.
REQ-029 SHALL cover: R0=0x00F0, R1=0x0FF0, ADD rd=0 rs1=0 rs2=1 -> R0=0x10E0 (old-value read); AND -> 0x00F0; OR -> 0x0FF0 from original values.
REQ-030 SHALL cover: instr_valid held high continuously with 3 instructions -> instr_ready high every 3rd cycle, exactly 3 done pulses.
REQ-031 SHALL cover: op 111 -> err pulse, registers unchanged; op 110 with MUL_EN, R0=0x0102, R1=0x0003 -> R2=0x0306 at cycle N+18; without MUL_EN -> err.
REQ-032 SHALL cover: rst asserted in cycle N+1 of an ADD -> no done, all registers 0x0000, instr_ready=1 after rst release.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer with a 4x16 register file and IDLE/EXEC/(MUL)/WB control.
// Define ALU_SEQ_MUL_EN to build the 16-cycle shift-add multiplier; otherwise op 110 is rejected.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [2:0]  instr_op,
  input  logic [1:0]  instr_rd,
  input  logic [1:0]  instr_rs1,
  input  logic [1:0]  instr_rs2,
  input  logic [15:0] instr_imm,
  output logic        done,
  output logic        err,
  input  logic [1:0]  dbg_sel,
  output logic [15:0] dbg_data
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpSlt = 3'b100;
  localparam logic [2:0] OpLdi = 3'b101;
  localparam logic [2:0] OpMul = 3'b110;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {StIdle, StExec, StWb, StMul} state_e;
`else
  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;
`endif

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  rd_q, rd_d;
  logic [15:0] imm_q, imm_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [15:0] result_q, result_d;
  logic [15:0] rf_q [4];
  logic [15:0] rf_d [4];
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef ALU_SEQ_MUL_EN
  logic [3:0]  cnt_q, cnt_d;
`endif

  function automatic logic is_reserved(input logic [2:0] op);
`ifdef ALU_SEQ_MUL_EN
    return op == 3'b111;
`else
    return (op == 3'b111) || (op == OpMul);
`endif
  endfunction

  assign instr_ready = (state_q == StIdle) && !rst;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_data    = rf_q[dbg_sel];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    rf_d     = rf_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (instr_valid) begin
          op_d    = instr_op;
          rd_d    = instr_rd;
          imm_d   = instr_imm;
          opa_d   = rf_q[instr_rs1];
          opb_d   = rf_q[instr_rs2];
          state_d = StExec;
          // err is registered, so decoding at accept lands the pulse in the EXEC cycle
          err_d   = is_reserved(instr_op);
        end
      end
      StExec: begin
        if (is_reserved(op_q)) begin
          state_d = StIdle;
        end else begin
          state_d = StWb;
          done_d  = 1'b1;
          case (op_q)
            OpAdd:   result_d = opa_q + opb_q;
            OpSub:   result_d = opa_q - opb_q;
            OpAnd:   result_d = opa_q & opb_q;
            OpOr:    result_d = opa_q | opb_q;
            OpSlt:   result_d = {15'd0, opa_q < opb_q};
            OpLdi:   result_d = imm_q;
`ifdef ALU_SEQ_MUL_EN
            OpMul: begin
              result_d = 16'd0;
              cnt_d    = 4'd0;
              state_d  = StMul;
              done_d   = 1'b0;
            end
`endif
            default: result_d = result_q;
          endcase
        end
      end
`ifdef ALU_SEQ_MUL_EN
      StMul: begin
        if (opb_q[cnt_q]) begin
          result_d = result_q + (opa_q << cnt_q);
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = StWb;
          done_d  = 1'b1;
        end
      end
`endif
      StWb: begin
        rf_d[rd_q] = result_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= 3'd0;
      rd_q     <= 2'd0;
      imm_q    <= 16'd0;
      opa_q    <= 16'd0;
      opb_q    <= 16'd0;
      result_q <= 16'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < 4; i++) rf_q[i] <= 16'd0;
`ifdef ALU_SEQ_MUL_EN
      cnt_q    <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
      for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
`ifdef ALU_SEQ_MUL_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer: arithmetic, latency, back-to-back, reject, reset.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  instr_op = 3'd0;
  logic [1:0]  instr_rd = 2'd0;
  logic [1:0]  instr_rs1 = 2'd0;
  logic [1:0]  instr_rs2 = 2'd0;
  logic [15:0] instr_imm = 16'd0;
  logic        done;
  logic        err;
  logic [1:0]  dbg_sel = 2'd0;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  alu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .instr_imm   (instr_imm),
    .done        (done),
    .err         (err),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  // Offer one instruction from idle; returns just after the accept edge (inside cycle N+1).
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [15:0] imm);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  // Issue and wait for done/err, then step past the final edge back into idle.
  task automatic run(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                     input logic [1:0] rs2, input logic [15:0] imm);
    int k;
    issue(op, rd, rs1, rs2, imm);
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || err) break;
    end
    if (k == 40) begin
      checks++; errors++;
      $display("FAIL run_timeout op %0d got no done/err within 40 cycles", op);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [1:0] sel, output logic [15:0] val);
    dbg_sel = sel;
    #1 val = dbg_data;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", instr_ready); end
    checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL rst_done_err got %b exp 00", {done, err}); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rst_reg%0d got %h exp 0000", i, v); end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", instr_ready); end
  endtask

  task automatic test_add_wrap;
    logic [15:0] v;
    run(3'b101, 2'd0, 2'd0, 2'd0, 16'hFFFF);
    run(3'b101, 2'd1, 2'd0, 2'd0, 16'h0001);
    run(3'b101, 2'd2, 2'd0, 2'd0, 16'h1234);
    dbg_sel = 2'd2;
    issue(3'b000, 2'd2, 2'd0, 2'd1, 16'h0);
    @(negedge clk);
    checks++; if ({instr_ready, done} !== 2'b00) begin errors++; $display("FAIL add_n1 ready_done got %b exp 00", {instr_ready, done}); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL add_n2_done got %b exp 1", done); end
    checks++; if (dbg_data !== 16'h1234) begin errors++; $display("FAIL add_n2_old got %h exp 1234", dbg_data); end
    @(negedge clk);
    checks++; if (dbg_data !== 16'h0000) begin errors++; $display("FAIL add_wrap got %h exp 0000", dbg_data); end
    checks++; if ({instr_ready, done} !== 2'b10) begin errors++; $display("FAIL add_n3 ready_done got %b exp 10", {instr_ready, done}); end
    read_reg(2'd0, v);
  endtask

  task automatic test_sub_slt;
    logic [15:0] v;
    run(3'b101, 2'd0, 2'd0, 2'd0, 16'h0000);
    run(3'b101, 2'd1, 2'd0, 2'd0, 16'h0001);
    run(3'b001, 2'd3, 2'd0, 2'd1, 16'h0);
    read_reg(2'd3, v);
    checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL sub_wrap got %h exp FFFF", v); end
    run(3'b100, 2'd2, 2'd0, 2'd1, 16'h0);
    read_reg(2'd2, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL slt_true got %h exp 0001", v); end
    run(3'b100, 2'd2, 2'd1, 2'd0, 16'h0);
    read_reg(2'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL slt_false got %h exp 0000", v); end
    run(3'b101, 2'd0, 2'd0, 2'd0, 16'h8000);
    run(3'b100, 2'd2, 2'd1, 2'd0, 16'h0);
    read_reg(2'd2, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL slt_unsigned got %h exp 0001", v); end
  endtask

  task automatic test_old_value;
    logic [15:0] v;
    run(3'b101, 2'd0, 2'd0, 2'd0, 16'h00F0);
    run(3'b101, 2'd1, 2'd0, 2'd0, 16'h0FF0);
    run(3'b000, 2'd0, 2'd0, 2'd1, 16'h0);
    read_reg(2'd0, v);
    checks++; if (v !== 16'h10E0) begin errors++; $display("FAIL add_rd_rs1 got %h exp 10E0", v); end
    run(3'b101, 2'd0, 2'd0, 2'd0, 16'h00F0);
    run(3'b010, 2'd0, 2'd0, 2'd1, 16'h0);
    read_reg(2'd0, v);
    checks++; if (v !== 16'h00F0) begin errors++; $display("FAIL and got %h exp 00F0", v); end
    run(3'b011, 2'd1, 2'd0, 2'd1, 16'h0);
    read_reg(2'd1, v);
    checks++; if (v !== 16'h0FF0) begin errors++; $display("FAIL or got %h exp 0FF0", v); end
  endtask

  task automatic test_back_to_back;
    logic [11:0]  ready_mask = '0;
    int           dones = 0;
    int           idx = 0;
    logic [15:0]  v;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = 3'b101; instr_rd = 2'd0; instr_imm = 16'h0011;
    for (int cyc = 0; cyc < 12; cyc++) begin
      ready_mask[cyc] = instr_ready;
      if (done) dones++;
      if (instr_ready && idx < 3) begin
        @(posedge clk);
        #1;
        idx++;
        if (idx < 3) begin
          instr_rd = idx[1:0];
          instr_imm = 16'h0011 * 16'(idx + 1);
        end else begin
          instr_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    checks++; if (ready_mask[8:0] !== 9'b001001001) begin errors++; $display("FAIL b2b_ready got %b exp 001001001", ready_mask[8:0]); end
    checks++; if (dones !== 3) begin errors++; $display("FAIL b2b_dones got %0d exp 3", dones); end
    read_reg(2'd2, v);
    checks++; if (v !== 16'h0033) begin errors++; $display("FAIL b2b_r2 got %h exp 0033", v); end
    read_reg(2'd1, v);
    checks++; if (v !== 16'h0022) begin errors++; $display("FAIL b2b_r1 got %h exp 0022", v); end
  endtask

  task automatic test_reserved;
    logic [15:0] v;
    issue(3'b111, 2'd0, 2'd1, 2'd2, 16'hBEEF);
    @(negedge clk);
    checks++; if ({err, done} !== 2'b10) begin errors++; $display("FAIL rsv_n1 err_done got %b exp 10", {err, done}); end
    @(negedge clk);
    checks++; if ({err, done, instr_ready} !== 3'b001) begin errors++; $display("FAIL rsv_n2 err_done_ready got %b exp 001", {err, done, instr_ready}); end
    read_reg(2'd0, v);
    checks++; if (v !== 16'h0011) begin errors++; $display("FAIL rsv_r0 got %h exp 0011", v); end
  endtask

  task automatic test_mul;
    logic [15:0] v;
    int          k;
    run(3'b101, 2'd0, 2'd0, 2'd0, 16'h0102);
    run(3'b101, 2'd1, 2'd0, 2'd0, 16'h0003);
    run(3'b101, 2'd2, 2'd0, 2'd0, 16'h5555);
    issue(3'b110, 2'd2, 2'd0, 2'd1, 16'h0);
`ifdef ALU_SEQ_MUL_EN
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done || err) break;
    end
    checks++; if (k !== 18) begin errors++; $display("FAIL mul_latency got %0d exp 18", k); end
    @(negedge clk);
    read_reg(2'd2, v);
    checks++; if (v !== 16'h0306) begin errors++; $display("FAIL mul_result got %h exp 0306", v); end
`else
    k = 0;
    @(negedge clk);
    checks++; if ({err, done} !== 2'b10) begin errors++; $display("FAIL mul_off_err got %b exp 10", {err, done}); end
    @(negedge clk);
    @(negedge clk);
    read_reg(2'd2, v);
    checks++; if (v !== 16'h5555) begin errors++; $display("FAIL mul_off_r2 got %h exp 5555", v); end
`endif
  endtask

  task automatic test_reset_mid;
    logic [15:0] v;
    int          seen_done = 0;
    issue(3'b000, 2'd3, 2'd0, 2'd1, 16'h0);
    #2 rst = 1'b1;
    #1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b exp 0", instr_ready); end
    repeat (2) begin
      @(negedge clk);
      if (done || err) seen_done++;
    end
    rst = 1'b0;
    #1;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rmid_release_ready got %b exp 1", instr_ready); end
    repeat (4) begin
      @(negedge clk);
      if (done || err) seen_done++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL rmid_pulses got %0d exp 0", seen_done); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rmid_reg%0d got %h exp 0000", i, v); end
    end
  endtask

  initial begin
    test_reset;
    test_add_wrap;
    test_sub_slt;
    test_old_value;
    test_back_to_back;
    test_reserved;
    test_mul;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
